instr_decode_pipe: RTL and testbench

- Parametrised, handshaked instruction-decode pipeline stage.
- Splits a fetched instruction word into opcode, two operands and class flags.
- Flags illegal opcodes and absorbs backpressure with a 2-entry skid buffer.
- Sits between the fetch stage and the execute stage; supports pipeline flush.

---
 rtl/instr_decode_pkg.sv | 62 ++++++
 rtl/decode_skid_buf.sv | 84 ++++++++
 rtl/instr_decode_pipe.sv | 126 ++++++++++++
 tb/tb_instr_decode_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_pkg
// Description : Shared definitions for the instruction-decode stage:
//               opcode encodings, the opcode legality check, the decoded
//               entry record and the skid-buffer state encoding.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package instr_decode_pkg;

  // Widths of the reference decoded-entry record below.
  localparam int OPC_W_DEF  = 8;
  localparam int DATA_W_DEF = 16;
  localparam int TAG_W_DEF  = 4;

  // Register-class opcodes
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_AND   = 8'h03;
  localparam logic [7:0] OP_OR    = 8'h04;
  localparam logic [7:0] OP_XOR   = 8'h05;
  localparam logic [7:0] OP_LOAD  = 8'h06;
  localparam logic [7:0] OP_STORE = 8'h07;
  localparam logic [7:0] OP_JMP   = 8'h08;
  localparam logic [7:0] OP_BEQ   = 8'h09;
  // Immediate-class opcodes (MSB set)
  localparam logic [7:0] OP_ADDI  = 8'h81;
  localparam logic [7:0] OP_SUBI  = 8'h82;
  localparam logic [7:0] OP_ANDI  = 8'h83;
  localparam logic [7:0] OP_ORI   = 8'h84;
  localparam logic [7:0] OP_XORI  = 8'h85;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Decoded entry at the default widths; the pipeline top re-declares the
  // same field layout at its own parameter widths.
  typedef struct packed {
    logic [OPC_W_DEF-1:0]  opcode;
    logic [DATA_W_DEF-1:0] op1;
    logic [DATA_W_DEF-1:0] op2;
    logic                  is_imm;
    logic                  illegal;
    logic [TAG_W_DEF-1:0]  tag;
  } dec_entry_t;

  function automatic logic opc_is_legal(input logic [7:0] opc);
    case (opc)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LOAD, OP_STORE, OP_JMP, OP_BEQ,
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : decode_skid_buf
// Description : 2-entry skid buffer for decoded entries. Output register
//               plus one skid register, strict FIFO order, flush support.
//               in_ready depends only on registered state and rst_n.
// Ports       : clk, rst_n (sync, active low), flush
//               in_valid/in_ready/in_data   - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module decode_skid_buf
  import instr_decode_pkg::*;
#(
  parameter type ENTRY_T = dec_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  ENTRY_T in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output ENTRY_T out_data
);

  state_t state, state_nxt;
  ENTRY_T out_q, skid_q;
  logic   accept, drain;
  logic   ld_out_in, ld_out_skid, ld_skid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_nxt = ST_TWO;
          else if (!accept && drain) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Output / datapath-control logic
  always_comb begin
    in_ready    = rst_n && (state != ST_TWO);
    out_valid   = (state != ST_EMPTY);
    accept      = in_valid && in_ready;
    drain       = out_valid && out_ready;
    // A flush discards same-cycle accepts, so no register loads then.
    ld_out_in   = !flush && accept &&
                  ((state == ST_EMPTY) || ((state == ST_ONE) && drain));
    ld_skid     = !flush && accept && (state == ST_ONE) && !drain;
    ld_out_skid = !flush && drain && (state == ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out_in)        out_q <= in_data;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= in_data;
    end
  end

  assign out_data = out_q;

endmodule
`default_nettype wire

// File: rtl/instr_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_pipe
// Description : Handshaked instruction-decode stage. Splits the instruction
//               into opcode/op1/op2, extends operands, flags immediate class
//               and illegal opcodes, and buffers through a 2-entry skid.
//               Optional macro INSTR_DECODE_PERF_CNT_EN adds drain counters;
//               without it perf_* are tied to zero.
// Ports       : clk, rst_n (sync, active low), flush
//               in_valid/in_ready/in_instr/in_tag - fetch side
//               out_valid/out_ready/out_opcode/out_op1/out_op2/out_is_imm/
//               out_illegal/out_tag - execute side
//               perf_decoded/perf_illegal - 32-bit drain counters
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_pipe
  import instr_decode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 8,
  parameter int OPR_W   = 12,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [DATA_W-1:0]  out_op1,
  output logic [DATA_W-1:0]  out_op2,
  output logic               out_is_imm,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag,
  output logic [31:0]        perf_decoded,
  output logic [31:0]        perf_illegal
);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              is_imm;
    logic              illegal;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic [OPC_W-1:0] opcode;
  logic [OPR_W-1:0] op1_raw, op2_raw;
  logic             is_imm, legal;
  entry_t           dec, held;

  assign opcode  = in_instr[OPC_W-1:0];
  assign op1_raw = in_instr[OPC_W +: OPR_W];
  assign op2_raw = in_instr[OPC_W+OPR_W +: OPR_W];
  assign is_imm  = opcode[OPC_W-1];

  // The legal opcode set is defined for 8-bit opcodes only.
  if (OPC_W == 8) begin : g_legal_8
    assign legal = opc_is_legal(opcode);
  end else begin : g_legal_none
    assign legal = 1'b0;
  end

  always_comb begin
    dec         = '0;
    dec.opcode  = opcode;
    dec.op1     = DATA_W'(op1_raw);
    dec.op2     = is_imm ? DATA_W'(signed'(op2_raw)) : DATA_W'(op2_raw);
    dec.is_imm  = is_imm;
    dec.illegal = !legal;
    dec.tag     = in_tag;
  end

  decode_skid_buf #(
    .ENTRY_T (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held)
  );

  assign out_opcode  = held.opcode;
  assign out_op1     = held.op1;
  assign out_op2     = held.op2;
  assign out_is_imm  = held.is_imm;
  assign out_illegal = held.illegal;
  assign out_tag     = held.tag;

`ifdef INSTR_DECODE_PERF_CNT_EN
  logic        drain;
  logic [31:0] decoded_q, illegal_q;

  // A drain coinciding with flush still counts; only reset clears.
  assign drain = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decoded_q <= '0;
      illegal_q <= '0;
    end else if (drain) begin
      decoded_q <= decoded_q + 32'd1;
      if (held.illegal) illegal_q <= illegal_q + 32'd1;
    end
  end

  assign perf_decoded = decoded_q;
  assign perf_illegal = illegal_q;
`else
  assign perf_decoded = '0;
  assign perf_illegal = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode_pipe
// Description : Scoreboard bench for instr_decode_pipe. Directed vectors push
//               hand-computed expected entries; a monitor pops and compares
//               on every downstream transfer. Perf checks follow the
//               INSTR_DECODE_PERF_CNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_tag;
  logic        in_ready, out_valid, out_is_imm, out_illegal;
  logic [7:0]  out_opcode;
  logic [15:0] out_op1, out_op2;
  logic [3:0]  out_tag;
  logic [31:0] perf_decoded, perf_illegal;

  always #5 clk = ~clk;

  instr_decode_pipe #(
    .INSTR_W(32), .OPC_W(8), .OPR_W(12), .DATA_W(16), .TAG_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_op1(out_op1), .out_op2(out_op2), .out_is_imm(out_is_imm),
    .out_illegal(out_illegal), .out_tag(out_tag),
    .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  tag;
    logic [7:0]  opc;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        imm;
    logic        ill;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output_tag", {28'd0, out_tag}, 32'hFFFF_FFFF);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check("out_tag",     {28'd0, out_tag},     {28'd0, e.tag});
        check("out_opcode",  {24'd0, out_opcode},  {24'd0, e.opc});
        check("out_op1",     {16'd0, out_op1},     {16'd0, e.op1});
        check("out_op2",     {16'd0, out_op2},     {16'd0, e.op2});
        check("out_is_imm",  {31'd0, out_is_imm},  {31'd0, e.imm});
        check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Drive one entry and wait (bounded) for its acceptance.
  task automatic send(input int idx);
    bit ok = 0;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_tag   = vecs[idx].tag;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(vecs[idx]);
        ok = 1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tagname, input int dec, input int ill);
`ifdef INSTR_DECODE_PERF_CNT_EN
    check({tagname, "_perf_decoded"}, perf_decoded, dec);
    check({tagname, "_perf_illegal"}, perf_illegal, ill);
`else
    check({tagname, "_perf_decoded"}, perf_decoded, 32'd0);
    check({tagname, "_perf_illegal"}, perf_illegal, 32'd0);
    if (dec < 0 || ill < 0) check("perf_arg", 32'd0, 32'd1);
`endif
  endtask

  task automatic check_zero_outputs(input string tagname);
    check({tagname, "_out_valid"},   {31'd0, out_valid},   32'd0);
    check({tagname, "_out_opcode"},  {24'd0, out_opcode},  32'd0);
    check({tagname, "_out_op1"},     {16'd0, out_op1},     32'd0);
    check({tagname, "_out_op2"},     {16'd0, out_op2},     32'd0);
    check({tagname, "_out_is_imm"},  {31'd0, out_is_imm},  32'd0);
    check({tagname, "_out_illegal"}, {31'd0, out_illegal}, 32'd0);
    check({tagname, "_out_tag"},     {28'd0, out_tag},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                instr         tag   opc    op1       op2       imm   ill
    vecs[0]  = '{32'h00A00501, 4'd0,  8'h01, 16'h0005, 16'h000A, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFF00381, 4'd1,  8'h81, 16'h0003, 16'hFFFF, 1'b1, 1'b0};
    vecs[2]  = '{32'hFFF00301, 4'd2,  8'h01, 16'h0003, 16'h0FFF, 1'b0, 1'b0};
    vecs[3]  = '{32'h12345642, 4'd3,  8'h42, 16'h0456, 16'h0123, 1'b0, 1'b1};
    vecs[4]  = '{32'h80000086, 4'd4,  8'h86, 16'h0000, 16'hF800, 1'b1, 1'b1};
    vecs[5]  = '{32'h7FF12309, 4'd5,  8'h09, 16'h0123, 16'h07FF, 1'b0, 1'b0};
    vecs[6]  = '{32'h800FFF85, 4'd6,  8'h85, 16'h0FFF, 16'hF800, 1'b1, 1'b0};
    vecs[7]  = '{32'h00000000, 4'd7,  8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000000A, 4'd8,  8'h0A, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{32'h555AAA80, 4'd9,  8'h80, 16'h0AAA, 16'h0555, 1'b1, 1'b1};
    vecs[10] = '{32'h000000FF, 4'd10, 8'hFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[11] = '{32'h00000008, 4'd11, 8'h08, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{32'h00000007, 4'd12, 8'h07, 16'h0000, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;

    // Reset state
    cycles(3);
    @(negedge clk);
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    check_zero_outputs("rst");
    check_perf("rst", 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency 1, then back-to-back stream of all vectors
    out_ready = 1'b1;
    send(0);
    @(negedge clk);
    check("latency1_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    for (int i = 1; i < 13; i++) send(i);
    cycles(3);
    check("stream_drained", sb.size(), 32'd0);
    check_perf("stream", 13, 5);

    // Backpressure: fill to TWO, then ordered drain
    out_ready = 1'b0;
    send(1);
    send(2);
    @(negedge clk);
    check("two_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("two_out_tag_head", {28'd0, out_tag}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(2);
    check("bp_drained_two_cycles", sb.size(), 32'd0);
    check_perf("bp", 15, 5);

    // Flush in ONE with a same-cycle drain and a same-cycle accept
    out_ready = 1'b0;
    send(7);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
    in_instr = vecs[3].instr; in_tag = vecs[3].tag;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("flush1_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush1_sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
    check_perf("flush1", 16, 5);

    // Flush in TWO with in_valid high
    send(8);
    send(9);
    flush = 1'b1; in_valid = 1'b1;
    in_instr = vecs[4].instr; in_tag = vecs[4].tag;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush2_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(4);
    check_perf("flush2", 16, 5);

    // Reset while in TWO
    out_ready = 1'b0;
    send(3);
    send(4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check_zero_outputs("midrst");
    check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
    check_perf("midrst", 0, 0);
    @(posedge clk); #1;

    // Recovery after reset
    out_ready = 1'b1;
    send(5);
    cycles(2);
    check("final_sb_empty", sb.size(), 32'd0);
    check_perf("final", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
